// File: rtl/test_value_uart_tx.sv
// Watches a 16-bit debug value and queues each change in a small FIFO.
// Each queued value is sent over an 8N1 UART line as "HHHH\r\n".
module test_value_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] test_value,
  input  logic        enable,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [15:0]      BIT_LAST   = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [15:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [15:0]      last_value;

  state_t      state;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_idx;
  logic [2:0]  char_idx;
  logic [15:0] record;
  logic [7:0]  shift_reg;
  logic [7:0]  cur_char;

  logic push_req;
  logic pop;
  logic accept;
  logic fifo_full;
  logic fifo_empty;
  logic bit_done;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_COUNT);
  assign push_req   = enable && (test_value != last_value);
  assign bit_done   = (clk_cnt == BIT_LAST);
  // A head is consumed when leaving IDLE or when the final LF stop bit ends.
  assign pop        = !fifo_empty &&
                      ((state == IDLE) || ((state == STOP) && bit_done && (char_idx == 3'd5)));
  assign accept     = push_req && (!fifo_full || pop);
  assign busy       = (state != IDLE) || !fifo_empty;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    cur_char = 8'h0A;
    case (char_idx)
      3'd0:    cur_char = hex_ascii(record[15:12]);
      3'd1:    cur_char = hex_ascii(record[11:8]);
      3'd2:    cur_char = hex_ascii(record[7:4]);
      3'd3:    cur_char = hex_ascii(record[3:0]);
      3'd4:    cur_char = 8'h0D;
      default: cur_char = 8'h0A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_mem[wr_ptr] <= test_value;
    end
  end

  // last_value follows every enabled change, even one dropped on a full FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_value <= 16'h0000;
      overflow   <= 1'b0;
    end else begin
      if (push_req) begin
        last_value <= test_value;
      end
      if (push_req && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({accept, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tx        <= 1'b1;
      clk_cnt   <= 16'd0;
      bit_idx   <= 3'd0;
      char_idx  <= 3'd0;
      record    <= 16'h0000;
      shift_reg <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            record   <= fifo_mem[rd_ptr];
            state    <= START;
            tx       <= 1'b0;
            clk_cnt  <= 16'd0;
            char_idx <= 3'd0;
          end
        end
        START: begin
          if (bit_done) begin
            clk_cnt   <= 16'd0;
            bit_idx   <= 3'd0;
            state     <= DATA;
            tx        <= cur_char[0];
            shift_reg <= {1'b0, cur_char[7:1]};
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            clk_cnt <= 16'd0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              tx        <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            clk_cnt <= 16'd0;
            if (char_idx == 3'd5) begin
              char_idx <= 3'd0;
              if (pop) begin
                record <= fifo_mem[rd_ptr];
                state  <= START;
                tx     <= 1'b0;
              end else begin
                state <= IDLE;
                tx    <= 1'b1;
              end
            end else begin
              char_idx <= char_idx + 3'd1;
              state    <= START;
              tx       <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_value_uart_tx.sv
// Directed bench for test_value_uart_tx: decodes the UART line at mid-bit
// and compares bytes, frame timing, busy and overflow against hand values.
module tb_test_value_uart_tx;

  localparam int CPB = 4;

  logic        clk;
  logic        reset;
  logic [15:0] test_value;
  logic        enable;
  logic        tx;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  test_value_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .test_value(test_value),
    .enable(enable),
    .tx(tx),
    .busy(busy),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitStart(input int budget, output int st, output bit ok);
    ok = 1'b0;
    st = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx == 1'b0) begin
        ok = 1'b1;
        st = cyc;
        break;
      end
    end
  endtask

  // Entered half a cycle into the start bit; leaves at the middle of the stop bit.
  task automatic receiveByte(input string tag, input logic [7:0] expByte);
    logic [7:0] b;
    b = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput({tag, "_startbit"}, 32'(tx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx;
    end
    checkOutput({tag, "_byte"}, 32'(b), 32'(expByte));
    repeat (CPB) @(negedge clk);
    checkOutput({tag, "_stopbit"}, 32'(tx), 32'd1);
  endtask

  task automatic receiveRecord(input string exp, input int budget, output int firstStart);
    logic [7:0] expB [6];
    int st;
    bit ok;
    for (int i = 0; i < 4; i++) expB[i] = exp[i];
    expB[4] = 8'h0D;
    expB[5] = 8'h0A;
    firstStart = 0;
    for (int k = 0; k < 6; k++) begin
      waitStart((k == 0) ? budget : 3, st, ok);
      checkOutput($sformatf("rec_%s_c%0d_found", exp, k), 32'(ok), 32'd1);
      if (k == 0) firstStart = st;
      else checkOutput($sformatf("rec_%s_c%0d_spacing", exp, k), 32'(st - firstStart), 32'(40 * k));
      receiveByte($sformatf("rec_%s_c%0d", exp, k), expB[k]);
    end
  endtask

  task automatic watchQuiet(input string tag, input int n);
    int lows;
    int busies;
    lows = 0;
    busies = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busies++;
    end
    checkOutput({tag, "_tx_low_cycles"}, 32'(lows), 32'd0);
    checkOutput({tag, "_busy_cycles"}, 32'(busies), 32'd0);
  endtask

  task automatic applyStimulus(input logic [15:0] value, input logic en);
    @(negedge clk);
    test_value = value;
    enable = en;
  endtask

  initial begin
    int c0;
    int f;
    int starts [5];
    string wrapStr [10];
    logic [15:0] wrapVal [10];
    int ofl;

    wrapVal = '{16'h1234, 16'hABCD, 16'hFFFF, 16'h0000, 16'h9ABC,
                16'hDEAD, 16'h5A5A, 16'hC3E7, 16'h0F0F, 16'h8001};
    wrapStr = '{"1234", "ABCD", "FFFF", "0000", "9ABC",
                "DEAD", "5A5A", "C3E7", "0F0F", "8001"};

    // Reset state and quiet idle after release.
    reset = 1'b1;
    test_value = 16'h0000;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_tx", 32'(tx), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    ofl = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (overflow !== 1'b0) ofl++;
      if (tx !== 1'b1) ofl++;
      if (busy !== 1'b0) ofl++;
    end
    checkOutput("post_reset_idle_violations", 32'(ofl), 32'd0);

    // Single record 0x1A2F.
    applyStimulus(16'h1A2F, 1'b1);
    c0 = cyc;
    receiveRecord("1A2F", 20, f);
    checkOutput("single_start_latency", 32'(f - c0), 32'd2);
    @(negedge clk);
    checkOutput("single_busy_last_stop", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("single_record_cycles", 32'(cyc - f), 32'd240);
    checkOutput("single_busy_after", 32'(busy), 32'd0);
    checkOutput("single_tx_idle", 32'(tx), 32'd1);
    checkOutput("single_overflow", 32'(overflow), 32'd0);
    watchQuiet("single_after", 100);

    // Overflow: six changes on consecutive edges; the sixth is dropped.
    @(negedge clk);
    c0 = cyc;
    fork
      begin
        for (int v = 1; v <= 6; v++) begin
          test_value = 16'(v);
          @(negedge clk);
        end
      end
      begin
        for (int r = 0; r < 5; r++) begin
          receiveRecord($sformatf("000%0d", r + 1), (r == 0) ? 20 : 3, starts[r]);
        end
      end
    join
    checkOutput("ovf_start_latency", 32'(starts[0] - c0), 32'd2);
    for (int r = 1; r < 5; r++) begin
      checkOutput($sformatf("ovf_rec%0d_offset", r), 32'(starts[r] - starts[0]), 32'(240 * r));
    end
    repeat (2) @(negedge clk);
    checkOutput("ovf_total_cycles", 32'(cyc - starts[0]), 32'd1200);
    checkOutput("ovf_busy_after", 32'(busy), 32'd0);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    watchQuiet("ovf_no_sixth", 300);
    checkOutput("ovf_flag_sticky", 32'(overflow), 32'd1);

    // Enable gating.
    applyStimulus(16'h00FF, 1'b0);
    watchQuiet("gate_disabled", 300);
    applyStimulus(16'h00FF, 1'b1);
    c0 = cyc;
    receiveRecord("00FF", 20, f);
    checkOutput("gate_start_latency", 32'(f - c0), 32'd2);
    repeat (2) @(negedge clk);
    watchQuiet("gate_held", 300);

    // Reset mid-frame during character 2 of 0xBEEF with a second record queued.
    applyStimulus(16'hBEEF, 1'b1);
    c0 = cyc;
    applyStimulus(16'h1234, 1'b1);
    begin
      int st;
      bit ok;
      waitStart(20, st, ok);
      checkOutput("midreset_start_found", 32'(ok), 32'd1);
      checkOutput("midreset_start_latency", 32'(st - c0), 32'd2);
      while (cyc < st + 90) @(negedge clk);
    end
    checkOutput("midreset_tx_before", 32'(tx), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_tx_async", 32'(tx), 32'd1);
    checkOutput("midreset_busy_async", 32'(busy), 32'd0);
    checkOutput("midreset_overflow_cleared", 32'(overflow), 32'd0);
    test_value = 16'h0000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    watchQuiet("midreset_after", 400);

    // Pointer wrap: ten spaced changes.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(wrapVal[i], 1'b1);
      c0 = cyc;
      receiveRecord(wrapStr[i], 20, f);
      checkOutput($sformatf("wrap%0d_start_latency", i), 32'(f - c0), 32'd2);
      while (cyc < c0 + 300) @(negedge clk);
    end
    checkOutput("wrap_overflow", 32'(overflow), 32'd0);
    checkOutput("wrap_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/test_value_uart_tx.md
TEST_VALUE_UART_TX -- requirements
Module: test_value_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of 16-bit record entries; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port test_value  input  16  debug value produced by MIPS_Top, sampled every clk.
REQ-006 SHALL have port enable  input  1  1 = change capture active; 0 = no new records.
REQ-007 SHALL have port tx  output  1  UART serial line, 8N1, idle high, registered.
REQ-008 SHALL have port busy  output  1  high while the FIFO is non-empty or a frame is in flight.
REQ-009 SHALL have port overflow  output  1  sticky flag, set when a record is dropped on a full FIFO.

Function
REQ-010 SHALL hold an internal last_value register (16 bit) that resets to 16'h0000.
REQ-011 SHALL, at a clk edge where enable=1 and test_value != last_value, write test_value into the FIFO and load it into last_value.
REQ-012 SHALL, if the FIFO is full at that edge and no pop occurs, drop the value, set overflow=1, and still update last_value.
REQ-013 SHALL accept the push and not set overflow when a push and a pop coincide on a full FIFO.
REQ-014 SHALL ignore test_value while enable=0, leaving last_value unchanged.
REQ-015 SHALL clear overflow only by reset.
REQ-016 SHALL implement FSM states IDLE, START, DATA and STOP, plus a character index 0..5 and a bit index 0..7.
REQ-017 SHALL, in IDLE with the FIFO non-empty, pop the head at the edge, enter START and drive tx=0 from that edge.
  - Latency: a record written at edge k with the FIFO empty and the FSM in IDLE gives tx=0 after edge k+1.
REQ-018 SHALL transmit each record as 6 characters in order:
  - 4 uppercase ASCII hex digits, MSB nibble first ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46);
  - then 0x0D, then 0x0A.
REQ-019 SHALL frame each character as 1 start bit (0), 8 data bits LSB first and 1 stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-020 SHALL start the next character's start bit on the edge immediately after a stop bit ends, with no idle gap within a record.
REQ-021 SHALL, at the end of the 0x0A stop bit:
  - pop the next record and go to START if the FIFO is non-empty (back-to-back records);
  - otherwise go to IDLE.
REQ-022 SHALL make a full record last exactly 60*CLKS_PER_BIT cycles.
REQ-023 SHALL drive busy=1 when state != IDLE or the FIFO count is not 0, and busy=0 otherwise.
REQ-024 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH with no loss or duplication.

Reset
REQ-025 SHALL, while reset=1 and independent of clk:
  - drive tx=1, busy=0 and overflow=0;
  - enter state IDLE;
  - set FIFO count to 0 with both pointers at 0;
  - set last_value=0;
  - clear the bit counter and the character index.
REQ-026 SHALL, on reset asserted mid-frame, abandon the frame immediately (tx=1) and not resume any partial or queued record after release.

Verification (sim with CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-027 Reset check: assert reset, then release with test_value=0 and enable=1 -> tx=1, busy=0 and overflow=0 held for 300 cycles, with no start bit.
REQ-028 Single record: test_value 0x0000->0x1A2F -> tx falls 1 cycle after the capture edge.
  - Decoded bytes are 0x31, 0x41, 0x32, 0x46, 0x0D, 0x0A over exactly 240 cycles.
  - busy falls on the cycle after the last stop bit.
REQ-029 Overflow: test_value takes values 1, 2, 3, 4, 5, 6 on 6 consecutive edges starting from idle.
  - Records 0001..0005 are transmitted back-to-back, 1200 cycles total.
  - 0006 is dropped and overflow=1 remains set.
REQ-030 Enable gating, in order:
  - enable=0 and test_value changes to 0x00FF -> no transmission;
  - enable rises -> record "00FF\r\n" is sent once;
  - enable stays high with the value held -> no further records.
REQ-031 Reset mid-frame: reset is pulsed during the DATA bits of character 2 of record 0xBEEF with a second record queued.
  - tx=1 asynchronously and busy=0.
  - Nothing is transmitted after release while test_value stays 0.
REQ-032 Pointer wrap: 10 changes of test_value, each spaced 300 cycles apart -> all 10 records are decoded in order with correct hex and overflow=0.
